// File: rtl/seq_stim_chk_pkg.sv
// Shared types and constants for the seq_stim_chk stimulus generator / response checker.
package seq_stim_chk_pkg;

   typedef enum logic [1:0] {StIdle, StSeed, StRun, StDone} state_e;

   localparam int unsigned CNT_W     = 8;
   localparam int unsigned SEL_MODES = 4;
   localparam int unsigned K_W       = 16;
   localparam logic [CNT_W-1:0] IDX_NONE = 8'hFF;
   localparam logic [CNT_W-1:0] IDX_SAT  = 8'hFE;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/seq_stim_chk_if.sv
// Stimulus/response bus between seq_stim_chk (master) and the register block under test (slave).
interface seq_stim_chk_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic [WIDTH-1:0] d_out;
   logic [1:0]       sel_out;
   logic [WIDTH-1:0] q_in;

   modport master (output d_out, output sel_out, input q_in);
   modport slave  (input d_out, input sel_out, output q_in);

endinterface

// File: rtl/seq_chk_monitor.sv
// Response checker: verifies q is an incrementing stream with bounded holds and keeps statistics.
module seq_chk_monitor
   import seq_stim_chk_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned START_VAL = 3,
   parameter int unsigned MAX_HOLD  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             check_en,
   input  logic             first_sample,
   input  logic [K_W-1:0]   k,
   input  logic [WIDTH-1:0] q_in,
   output logic             err_hit,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] hold_cnt,
   output logic [CNT_W-1:0] first_err_idx
);

   logic [WIDTH-1:0] prev;
   logic [CNT_W-1:0] run_len;
   logic [CNT_W-1:0] idx_sat;
   logic             hold_ok;
   logic             is_hold;

   assign hold_ok = (32'(run_len) + 32'd1) <= MAX_HOLD;
   assign idx_sat = (k >= K_W'(IDX_SAT)) ? IDX_SAT : k[CNT_W-1:0];

   always_comb begin
      err_hit = 1'b0;
      is_hold = 1'b0;
      if (check_en) begin
         if (first_sample) begin
            err_hit = (q_in != WIDTH'(START_VAL));
         end else if (q_in == prev + WIDTH'(1)) begin
            err_hit = 1'b0;
         end else if (q_in == prev) begin
            if (hold_ok) is_hold = 1'b1;
            else         err_hit = 1'b1;
         end else begin
            err_hit = 1'b1;
         end
      end
   end

   // prev always follows q so that a single jump costs exactly one error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev          <= '0;
         run_len       <= '0;
         err_cnt       <= '0;
         hold_cnt      <= '0;
         first_err_idx <= IDX_NONE;
      end else if (clear) begin
         prev          <= '0;
         run_len       <= '0;
         err_cnt       <= '0;
         hold_cnt      <= '0;
         first_err_idx <= IDX_NONE;
      end else if (check_en) begin
         prev <= q_in;
         if (err_hit) begin
            err_cnt <= sat_inc(err_cnt);
            if (first_err_idx == IDX_NONE) first_err_idx <= idx_sat;
            run_len <= '0;
         end else if (is_hold) begin
            hold_cnt <= sat_inc(hold_cnt);
            run_len  <= sat_inc(run_len);
         end else begin
            run_len <= '0;
         end
      end
   end

endmodule

// File: rtl/seq_stim_chk.sv
// Top: FSM, run index and stimulus generation for seq_stim_chk.
// Define SEQ_STIM_CHK_HALT_EN to stop the run on the first check failure.
module seq_stim_chk
   import seq_stim_chk_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned CYCLES_PER_SEL = 5,
   parameter int unsigned START_VAL      = 3,
   parameter int unsigned LAT            = 1,
   parameter int unsigned MAX_HOLD       = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   seq_stim_chk_if.master   bus,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] hold_cnt,
   output logic [CNT_W-1:0] first_err_idx
);

`ifdef SEQ_STIM_CHK_HALT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   // LAT must be at least 1.
   localparam logic [K_W-1:0] K_LAST    = K_W'(SEL_MODES * CYCLES_PER_SEL - 1);
   localparam logic [K_W-1:0] SEG_LAST  = K_W'(CYCLES_PER_SEL - 1);
   localparam logic [K_W-1:0] SEED_LAST = K_W'(LAT - 1);

   state_e           state;
   logic [K_W-1:0]   seed_cnt;
   logic [K_W-1:0]   k;
   logic [K_W-1:0]   seg;
   logic [WIDTH-1:0] d_q;
   logic [1:0]       sel_q;
   logic             err_hit;
   logic             launch;

   assign launch      = start && ((state == StIdle) || (state == StDone));
   assign bus.d_out   = d_q;
   assign bus.sel_out = sel_q;
   assign pass        = done && (err_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= StIdle;
         seed_cnt <= '0;
         k        <= '0;
         seg      <= '0;
         d_q      <= WIDTH'(START_VAL);
         sel_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  state    <= StSeed;
                  seed_cnt <= '0;
                  d_q      <= WIDTH'(START_VAL);
                  sel_q    <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            StSeed: begin
               if (seed_cnt == SEED_LAST) begin
                  state <= StRun;
                  k     <= '0;
                  seg   <= '0;
                  d_q   <= WIDTH'(START_VAL + 1);
               end else begin
                  seed_cnt <= seed_cnt + K_W'(1);
               end
            end
            StRun: begin
               // Stimulus freezes at its last driven values when the run ends.
               if ((HaltEn && err_hit) || (k == K_LAST)) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  k   <= k + K_W'(1);
                  d_q <= d_q + WIDTH'(1);
                  if (seg == SEG_LAST) begin
                     seg   <= '0;
                     sel_q <= sel_q + 2'd1;
                  end else begin
                     seg <= seg + K_W'(1);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   seq_chk_monitor #(
      .WIDTH    (WIDTH),
      .START_VAL(START_VAL),
      .MAX_HOLD (MAX_HOLD)
   ) u_monitor (
      .clk          (clk),
      .reset        (reset),
      .clear        (launch),
      .check_en     (state == StRun),
      .first_sample (k == '0),
      .k            (k),
      .q_in         (bus.q_in),
      .err_hit      (err_hit),
      .err_cnt      (err_cnt),
      .hold_cnt     (hold_cnt),
      .first_err_idx(first_err_idx)
   );

endmodule
